ps_mac_acc: RTL

- Precision-scalable, pipelined multiply-accumulate unit for neural-network dot products.
- Three precision modes on one 8-bit datapath: one 8x8 product, two 4x4 lane products, or four 2x2 lane products.
- In sub-word modes the lane products of a beat are summed before being added to a saturating signed accumulator.
- Valid/ready streaming interface with first/last group framing; sits between the operand buffers and the activation stage of a neuron.

---
 rtl/ps_mac_pkg.sv | 50 +++++
 rtl/ps_lane_mul.sv | 52 +++++
 rtl/ps_mac_acc.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ps_mac_pkg.sv
// Shared types and constants for the precision-scalable MAC.
//   mode_e      : precision mode encoding (reserved code runs as 8x8)
//   LANE_W_*    : lane widths per mode; LANE_SH_* = log2(2-bit cells per lane)
//   PSUM_W      : width of the signed per-beat lane-product sum
//   s1_beat_t   : payload held in the first pipeline stage
//   cell_mul    : 2x2 partial-product cell with per-operand signedness
package ps_mac_pkg;

  typedef enum logic [1:0] {
    MODE_8X8  = 2'b00,
    MODE_4X4  = 2'b01,
    MODE_2X2  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam int unsigned OPND_W     = 8;
  localparam int unsigned CELL_W     = 2;
  localparam int unsigned NUM_CELLS  = OPND_W / CELL_W;
  localparam int unsigned CELL_P_W   = 6;
  localparam int unsigned PSUM_W     = 18;

  localparam int unsigned LANE_W_8X8 = 8;
  localparam int unsigned LANE_W_4X4 = 4;
  localparam int unsigned LANE_W_2X2 = 2;

  localparam int unsigned LANE_SH_8X8 = $clog2(LANE_W_8X8 / CELL_W);
  localparam int unsigned LANE_SH_4X4 = $clog2(LANE_W_4X4 / CELL_W);
  localparam int unsigned LANE_SH_2X2 = $clog2(LANE_W_2X2 / CELL_W);

  typedef struct packed {
    logic [PSUM_W-1:0] p;
    logic              first;
    logic              last;
  } s1_beat_t;

  // A digit is signed only when it is the top digit of a signed lane.
  function automatic logic signed [CELL_P_W-1:0] cell_mul(
    input logic [CELL_W-1:0] a,
    input logic              a_signed,
    input logic [CELL_W-1:0] b,
    input logic              b_signed
  );
    logic signed [CELL_P_W-1:0] ae;
    logic signed [CELL_P_W-1:0] be;
    ae = CELL_P_W'($signed({a_signed & a[CELL_W-1], a}));
    be = CELL_P_W'($signed({b_signed & b[CELL_W-1], b}));
    return ae * be;
  endfunction

endpackage

// File: rtl/ps_lane_mul.sv
// Combinational precision-scalable multiplier.
//   mode_i : precision mode (mode_e encoding)
//   sx_i   : mr lanes signed
//   sy_i   : md lanes signed
//   mr_i   : multiplier operand, lanes packed from bit 0
//   md_i   : multiplicand operand, same layout
//   p_o    : signed sum of all lane products of the beat
module ps_lane_mul
  import ps_mac_pkg::*;
(
  input  logic [1:0]        mode_i,
  input  logic              sx_i,
  input  logic              sy_i,
  input  logic [OPND_W-1:0] mr_i,
  input  logic [OPND_W-1:0] md_i,
  output logic [PSUM_W-1:0] p_o
);

  int unsigned       lane_sh;
  int unsigned       lane_mask;
  logic [PSUM_W-1:0] psum;
  logic signed [PSUM_W-1:0] term;

  // Cells per lane as a power of two; reserved mode runs as 8x8.
  always_comb begin
    case (mode_e'(mode_i))
      MODE_4X4: lane_sh = LANE_SH_4X4;
      MODE_2X2: lane_sh = LANE_SH_2X2;
      default:  lane_sh = LANE_SH_8X8;
    endcase
    lane_mask = (32'd1 << lane_sh) - 32'd1;
  end

  // Only cell pairs inside the same lane contribute; their weight is the
  // digit position inside the lane, so lane products land unshifted.
  always_comb begin
    psum = '0;
    term = '0;
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      for (int unsigned j = 0; j < NUM_CELLS; j++) begin
        if ((i >> lane_sh) == (j >> lane_sh)) begin
          term = PSUM_W'(cell_mul(mr_i[i*CELL_W +: CELL_W], sx_i && ((i & lane_mask) == lane_mask),
                                  md_i[j*CELL_W +: CELL_W], sy_i && ((j & lane_mask) == lane_mask)));
          psum = psum + (term << (CELL_W * ((i & lane_mask) + (j & lane_mask))));
        end
      end
    end
  end

  assign p_o = psum;

endmodule

// File: rtl/ps_mac_acc.sv
// Pipelined precision-scalable multiply-accumulate with group framing.
//   clk, rst_n          : clock, async active-low reset
//   mode, sx, sy        : precision mode and operand signedness per beat
//   mr, md              : packed lane operands
//   in_first, in_last   : group framing of the beat
//   in_valid, in_ready  : input handshake (in_ready is the pipeline enable)
//   acc_out, out_sat    : group result and group overflow flag
//   out_valid, out_ready: output handshake
// Pipeline: S1 lane products -> S2 accumulate -> output register.
module ps_mac_acc
  import ps_mac_pkg::*;
#(
  parameter int unsigned ACC_W  = 24,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              sx,
  input  logic              sy,
  input  logic [OPND_W-1:0] mr,
  input  logic [OPND_W-1:0] md,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic              en;
  logic              accept;
  logic [PSUM_W-1:0] p;

  s1_beat_t          s1_q, s1_d;
  logic              s1_vld_q, s1_vld_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;
  logic              s2_vld_q, s2_vld_d;
  logic              s2_last_q, s2_last_d;
  logic [ACC_W-1:0]  acc_out_q, acc_out_d;
  logic              out_sat_q, out_sat_d;
  logic              out_valid_q, out_valid_d;

  logic [ACC_W-1:0]  base;
  logic [SUM_W-1:0]  sum;
  logic              ovf;
  logic [ACC_W-1:0]  res;

  ps_lane_mul u_lane_mul (
    .mode_i (mode),
    .sx_i   (sx),
    .sy_i   (sy),
    .mr_i   (mr),
    .md_i   (md),
    .p_o    (p)
  );

  // A held result with no taker freezes the whole pipeline.
  assign en       = !(out_valid_q && !out_ready);
  assign in_ready = en;
  assign accept   = in_valid && en;

  // One guard bit above the accumulator exposes signed overflow.
  always_comb begin
    base = s1_q.first ? '0 : acc_q;
    sum  = {base[ACC_W-1], base} + {{(SUM_W-PSUM_W){s1_q.p[PSUM_W-1]}}, s1_q.p};
    ovf  = sum[ACC_W] != sum[ACC_W-1];
    res  = sum[ACC_W-1:0];
    if (SAT_EN && ovf) begin
      res = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Next-state for all stages; everything holds while stalled.
  always_comb begin
    s1_d        = s1_q;
    s1_vld_d    = s1_vld_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    s2_vld_d    = s2_vld_q;
    s2_last_d   = s2_last_q;
    acc_out_d   = acc_out_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    if (en) begin
      s1_vld_d = accept;
      if (accept) begin
        s1_d.p     = p;
        s1_d.first = in_first;
        s1_d.last  = in_last;
      end
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        acc_d     = res;
        sat_d     = (s1_q.first ? 1'b0 : sat_q) | ovf;
        s2_last_d = s1_q.last;
      end
      // acc_q/sat_q still hold the completed group here.
      if (s2_vld_q && s2_last_q) begin
        acc_out_d   = acc_q;
        out_sat_d   = sat_q;
        out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s1_vld_q    <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_out_q   <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s1_vld_q    <= s1_vld_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      s2_vld_q    <= s2_vld_d;
      s2_last_q   <= s2_last_d;
      acc_out_q   <= acc_out_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule
